// File: rtl/iir_pole_pkg.sv
// Shared parameters, feedback coefficients and FSM encoding for the IIR pole section.
// Coefficients are Q9 (a0 = 512) and are subtracted from the accumulator.
package iir_pole_pkg;

    localparam int DW    = 21;
    localparam int CW    = 12;
    localparam int SHIFT = 9;
    localparam int AW    = 40;
    localparam int PW    = DW + CW;
    localparam int NTAPS = 7;

    typedef logic signed [CW-1:0] coef_t;
    typedef logic signed [DW-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam sample_t SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam sample_t SAT_MIN = {1'b1, {(DW-1){1'b0}}};

    localparam coef_t A_COEF [1:NTAPS] = '{
        -12'sd1083, 12'sd1206, -12'sd746, 12'sd347, -12'sd101, 12'sd19, -12'sd2
    };

endpackage

// File: rtl/iir_pole_sat.sv
// Scales the accumulator back to sample precision (arithmetic shift, floor rounding)
// and clamps it to the signed DW-bit range, flagging when a clamp happened.
module iir_pole_sat
    import iir_pole_pkg::*;
(
    input  logic signed [AW-1:0] acc,
    output logic signed [DW-1:0] y,
    output logic                 clamped
);

    localparam logic signed [AW-1:0] R_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] R_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW-1:0] r;

    assign r = acc >>> SHIFT;

    always_comb begin
        y       = r[DW-1:0];
        clamped = 1'b0;
        if (r > R_MAX) begin
            y       = SAT_MAX;
            clamped = 1'b1;
        end else if (r < R_MIN) begin
            y       = SAT_MIN;
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/iir_pole_serial.sv
// Recursive section of the 7th-order IIR: one multiplier walks the seven feedback taps,
// nine clocks per sample (accept, seven MAC steps, output).
module iir_pole_serial
    import iir_pole_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] din,
    input  logic                 din_valid,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 sat_flag,
    output logic                 overrun_flag
);

    // Handshake: din_valid is a one-cycle strobe, taken only in IDLE; a strobe in any
    // other state is dropped and recorded in overrun_flag. dout_valid is a one-cycle
    // strobe with no back-pressure; dout holds between strobes.

    localparam logic [2:0] TAP_LAST = 3'(NTAPS);

    state_t               state;
    logic [2:0]           k;
    logic signed [AW-1:0] acc;
    logic signed [DW-1:0] y_hist [1:NTAPS];

    coef_t                tap_c;
    logic signed [DW-1:0] tap_y;
    logic signed [PW-1:0] prod;
    logic signed [DW-1:0] sat_y;
    logic                 sat_clamped;

    always_comb begin
        tap_c = '0;
        tap_y = '0;
        for (int i = 1; i <= NTAPS; i++) begin
            if (k == 3'(i)) begin
                tap_c = A_COEF[i];
                tap_y = y_hist[i];
            end
        end
    end

    assign prod = tap_c * tap_y;

    iir_pole_sat u_sat (
        .acc     (acc),
        .y       (sat_y),
        .clamped (sat_clamped)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            acc          <= '0;
            dout         <= '0;
            dout_valid   <= 1'b0;
            busy         <= 1'b0;
            sat_flag     <= 1'b0;
            overrun_flag <= 1'b0;
            for (int i = 1; i <= NTAPS; i++) y_hist[i] <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (din_valid && state != IDLE) overrun_flag <= 1'b1;
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        acc   <= AW'(din) <<< SHIFT;
                        k     <= 3'd1;
                        state <= MAC;
                        busy  <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= acc - AW'(prod);
                    k   <= k + 3'd1;
                    if (k == TAP_LAST) state <= DONE;
                end
                DONE: begin
                    // History takes the clamped value so the loop stays bounded.
                    dout       <= sat_y;
                    dout_valid <= 1'b1;
                    sat_flag   <= sat_flag | sat_clamped;
                    for (int i = NTAPS; i >= 2; i--) y_hist[i] <= y_hist[i-1];
                    y_hist[1]  <= sat_y;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iir_pole_serial.sv
// Bench for iir_pole_serial: fixed vector table, hand-built overrun/reset sequences,
// then randomized max-rate samples checked against an arithmetic reference model.
module tb_iir_pole_serial;

    localparam int DW = 21;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] din;
    logic                 din_valid;
    logic signed [DW-1:0] dout;
    logic                 dout_valid;
    logic                 busy;
    logic                 sat_flag;
    logic                 overrun_flag;

    iir_pole_serial dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_valid    (din_valid),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .busy         (busy),
        .sat_flag     (sat_flag),
        .overrun_flag (overrun_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_err = 0;

    localparam int REF_A [1:7] = '{-1083, 1206, -746, 347, -101, 19, -2};
    int yh [1:7];
    bit m_sat;
    logic [DW-1:0] exp_q [$];

    typedef struct {
        bit do_rst;
        int din;
        int exp_y;
        bit exp_sat;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int x, output int y);
        longint acc, q;
        acc = longint'(x) * 512;
        for (int i = 1; i <= 7; i++) acc = acc - longint'(REF_A[i]) * longint'(yh[i]);
        q = acc / 512;
        if ((acc % 512) != 0 && acc < 0) q = q - 1;
        if (q > 1048575) begin
            q = 1048575;
            m_sat = 1'b1;
        end else if (q < -1048576) begin
            q = -1048576;
            m_sat = 1'b1;
        end
        for (int i = 7; i > 1; i--) yh[i] = yh[i-1];
        yh[1] = int'(q);
        y = int'(q);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        din = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) yh[i] = 0;
        m_sat = 1'b0;
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_overrun_flag", overrun_flag, 0);
    endtask

    // One sample at maximum rate: strobe, then watch for the result strobe.
    task automatic run_sample(input int x, input int exp_y, input bit exp_sat,
                              input bit exp_ovr, input string name);
        logic [DW-1:0] xv;
        int lat;
        int busy_bad;
        bit seen;
        xv = x[DW-1:0];
        @(negedge clk);
        check({name, "_strobe_width"}, dout_valid, 0);
        din = xv;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din = '0;
        check({name, "_busy_start"}, busy, 1);
        seen = 1'b0;
        lat = 0;
        busy_bad = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (dout_valid) begin
                seen = 1'b1;
                lat = c;
            end else if (busy !== 1'b1) begin
                busy_bad++;
            end
        end
        if (!seen) begin
            check({name, "_timeout"}, 0, 1);
        end else begin
            check({name, "_latency"}, lat, 8);
            check({name, "_dout"}, dout, exp_y);
            check({name, "_busy_during"}, busy_bad, 0);
            check({name, "_busy_end"}, busy, 0);
            check({name, "_sat_flag"}, sat_flag, exp_sat);
            check({name, "_overrun_flag"}, overrun_flag, exp_ovr);
        end
    endtask

    initial begin
        int y, pulses, lat, x;
        logic signed [DW-1:0] got;

        rst = 1'b0;
        din = '0;
        din_valid = 1'b0;

        tbl[0] = '{1'b1, 1024, 1024, 1'b0};
        tbl[1] = '{1'b0, 0, 2166, 1'b0};
        tbl[2] = '{1'b0, 0, 2169, 1'b0};
        tbl[3] = '{1'b1, -1, -1, 1'b0};
        tbl[4] = '{1'b0, 0, -3, 1'b0};
        tbl[5] = '{1'b1, 1048575, 1048575, 1'b0};
        tbl[6] = '{1'b0, 1048575, 1048575, 1'b1};
        tbl[7] = '{1'b0, 0, -251904, 1'b1};

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].do_rst) do_reset();
            run_sample(tbl[i].din, tbl[i].exp_y, tbl[i].exp_sat, 1'b0, $sformatf("vec%0d", i));
        end

        // Overrun during MAC: second strobe lands on E3 and must be ignored.
        do_reset();
        @(negedge clk);
        din = 21'sd1024;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        din = 21'sd5000;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din = '0;
        pulses = 0;
        lat = 0;
        got = '0;
        for (int c = 4; c <= 24; c++) begin
            @(negedge clk);
            if (dout_valid) begin
                pulses++;
                if (pulses == 1) begin
                    lat = c;
                    got = dout;
                end
            end
        end
        check("ovr_mac_pulses", pulses, 1);
        check("ovr_mac_latency", lat, 8);
        check("ovr_mac_dout", got, 1024);
        check("ovr_mac_flag", overrun_flag, 1);

        // Overrun in DONE (strobe on E8) is dropped; the next real sample sees one history entry.
        do_reset();
        @(negedge clk);
        din = 21'sd1024;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (7) @(negedge clk);
        din = 21'sd7;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din = '0;
        check("ovr_done_valid", dout_valid, 1);
        check("ovr_done_dout", dout, 1024);
        check("ovr_done_flag", overrun_flag, 1);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dout_valid) pulses++;
        end
        check("ovr_done_no_extra", pulses, 0);
        run_sample(0, 2166, 1'b0, 1'b1, "ovr_done_next");

        // Reset mid-MAC: partial result discarded, history cleared.
        do_reset();
        run_sample(1024, 1024, 1'b0, 1'b0, "pre_abort");
        @(negedge clk);
        din = 21'sd1024;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        din = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_dout", dout, 0);
        check("abort_busy", busy, 0);
        check("abort_dout_valid", dout_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dout_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        run_sample(1024, 1024, 1'b0, 1'b0, "post_abort");

        // Randomized max-rate stream against the reference model.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 2097151)) - 1048576;
            else x = int'($urandom_range(0, 40000)) - 20000;
            model_step(x, y);
            exp_q.push_back(y[DW-1:0]);
            run_sample(x, int'($signed(exp_q.pop_front())), m_sat, 1'b0, $sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iir_pole_serial.md
# iir_pole_serial

Recursive (pole) section of the 7th-order IIR filter: consumes each sample produced by the symmetric zero section and computes y[n] = (x[n]·512 − Σ a_i·y[n−i], i=1..7) >>> 9. A single time-shared multiplier-accumulator walks the seven feedback taps under a small FSM. Sits directly downstream of the zero-section output (21-bit signed) and drives the filter output register.

## Interface
- DW, 21, input/output sample width (signed)
- CW, 12, feedback coefficient width (signed)
- SHIFT, 9, coefficient scale (a0 = 2^SHIFT = 512)
- AW, 40, accumulator width (signed)

- clk  in  1  system clock (≥ 9× sample rate)
- rst  in  1  reset; asynchronous, active-high
- din  in  DW  zero-section sample, signed
- din_valid  in  1  one-cycle strobe; din valid when high
- dout  out  DW  filtered sample, signed, saturated
- dout_valid  out  1  one-cycle strobe with each new dout
- busy  out  1  registered; high whenever state ≠ IDLE
- sat_flag  out  1  sticky; set when any output was clamped
- overrun_flag  out  1  sticky; set when din_valid arrives while busy

## Operation
- Reset: all outputs 0; acc 0; y_hist[1..7] 0; tap index 0; state IDLE.
- FSM states IDLE → MAC → DONE → IDLE.
- IDLE: din_valid=1 → acc ← sign-extended din <<< SHIFT, k ← 1, state MAC. Otherwise hold.
- MAC: each cycle acc ← acc − A[k]·y_hist[k] (full-precision signed product, sign-extended to AW); k increments; after k=7 processed → DONE.
- DONE: r = acc >>> SHIFT (arithmetic, floor rounding); dout ← clamp(r, −2^20, 2^20−1); sat_flag |= clamped; y_hist shifts (y_hist[1] ← clamped value, y_hist[i+1] ← y_hist[i]); dout_valid ← 1; state IDLE.
- Feedback uses the saturated value, never the unclamped one.
- din_valid while busy: sample dropped, overrun_flag ← 1, computation in progress unaffected.
- dout holds its value between strobes.
- Sticky flags cleared only by rst.
- Coefficients A[1..7] = −1083, 1206, −746, 347, −101, 19, −2 (Q9).

## Timing
- Accept edge E0 (din_valid sampled in IDLE); MAC updates on E1..E7; DONE on E8.
- dout/dout_valid registered at E8: dout_valid high for exactly the cycle after E8; latency 8 clocks.
- busy high from the cycle after E0 through the cycle after E7; low after E8.
- Next sample accepted at E9 earliest; sustained throughput one sample per 9 clocks.
- din_valid at E8 (state DONE) counts as overrun.
- rst mid-operation: immediate return to reset values, history cleared, partial result discarded, no dout_valid.

## Structure
- Package iir_pole_pkg: DW, CW, SHIFT, AW, coefficient array A[1..7], FSM state enum (IDLE, MAC, DONE), clamp limits.
- One sub-module: iir_pole_sat — combinational arithmetic shift + saturation returning value and clamp flag.
- Top holds FSM, accumulator, tap index, history shift register, flags.

## Test plan
- Impulse: din=1024 then zeros, spaced 9 clocks → dout sequence 1024, 2166, 2169; each dout_valid exactly 8 clocks after its din_valid.
- Negative rounding: rst, din=−1 then 0 → dout −1, then −3 (floor of −2.115); sat_flag stays 0.
- Saturation: din=1048575 twice → first dout 1048575, second clamped to 1048575, sat_flag=1; third input 0 uses clamped history.
- Overrun: din_valid at E0 and E3 → one dout_valid only, overrun_flag=1, result equals single-sample value.
- Reset mid-MAC: rst pulsed at E4 of an impulse → no dout_valid, all outputs 0; next impulse 1024 gives dout 1024 (history clean).
- Back-to-back at max rate (din_valid every 9 clocks, random din) → matches bit-accurate reference model, no overrun.
